// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_MUL  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SUBI = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Immediate forms take their second operand from the immediate port.
    function automatic logic uses_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_shift_add_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic                 busy;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc_next;

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= CW'(WIDTH - 1);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
            if (count == '0) begin
                busy <= 1'b0;
            end
        end
    end

    // The final partial sum is presented combinationally so the caller can
    // capture the full product on the same edge that retires the last bit.
    assign done    = busy && (count == '0);
    assign product = acc_next;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, status flags and a multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [WIDTH-1:0]  input1,
    input  logic [WIDTH-1:0]  input2,
    input  logic [WIDTH-1:0]  immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_ovf,
    output logic              op_err
);

    state_t state, state_next;

    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic                 capture_alu;
    logic                 capture_mul;

    logic [WIDTH-1:0]     operand;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [SHW-1:0]       shamt;
    logic                 big_shift;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic                 alu_err;

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (input1),
        .b       (input2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (alu_op == OP_MUL) ? MUL : DONE;
            MUL:  if (mul_done) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
        mul_start   = (state == IDLE) && in_valid && (alu_op == OP_MUL);
        capture_alu = (state == IDLE) && in_valid && (alu_op != OP_MUL);
        capture_mul = (state == MUL) && mul_done;
    end

    // Single-cycle datapath works straight off the ports; the accept edge captures it.
    always_comb begin
        operand   = uses_imm(alu_op) ? immediate : input2;
        sum_ext   = {1'b0, input1} + {1'b0, operand};
        diff_ext  = {1'b0, input1} - {1'b0, operand};
        shamt     = input2[SHW-1:0];
        big_shift = |input2[WIDTH-1:SHW];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (alu_op)
            OP_ZERO, OP_MUL: alu_res = '0;
            OP_ADD, OP_ADDI: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (input1[WIDTH-1] == operand[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB, OP_SUBI: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (input1[WIDTH-1] != operand[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SLL: alu_res = big_shift ? '0 : (input1 << shamt);
            OP_SRL: alu_res = big_shift ? '0 : (input1 >> shamt);
            OP_SRA: alu_res = big_shift ? {WIDTH{input1[WIDTH-1]}}
                                        : WIDTH'($signed(input1) >>> shamt);
            OP_AND: alu_res = input1 & input2;
            OP_OR:  alu_res = input1 | input2;
            OP_XOR: alu_res = input1 ^ input2;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            op_err     <= 1'b0;
        end else if (capture_alu) begin
            result     <= alu_res;
            flag_zero  <= (alu_res == '0);
            flag_carry <= alu_carry;
            flag_ovf   <= alu_ovf;
            op_err     <= alu_err;
        end else if (capture_mul) begin
            result     <= mul_product[WIDTH-1:0];
            flag_zero  <= (mul_product[WIDTH-1:0] == '0);
            flag_carry <= |mul_product[2*WIDTH-1:WIDTH];
            flag_ovf   <= 1'b0;
            op_err     <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Generalises operand width and adds a valid/ready handshake on input and output, status flags, arithmetic shift, bitwise ops, and a multi-cycle shift-add multiply.
- Sits between the register-file read stage and writeback. It holds one operation at a time and stalls upstream via in_ready while busy.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of two).
- SHW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept (high only in IDLE)
- alu_op  input  4  opcode (see Behaviour)
- input1  input  WIDTH  operand A
- input2  input  WIDTH  operand B (register)
- immediate  input  WIDTH  immediate operand
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream consumes result
- result  output  WIDTH  registered result
- flag_zero  output  1  result == 0
- flag_carry  output  1  carry/borrow/mul-overflow (see below)
- flag_ovf  output  1  signed overflow (add/sub forms only)
- op_err  output  1  unsupported opcode was executed

Behaviour:
- Opcodes:
  - 0000 zero
  - 0001 mul (low WIDTH bits, unsigned)
  - 0010 A+B
  - 0011 A-B
  - 0100 A<<B
  - 0101 A>>B logical
  - 0110 A+imm
  - 0111 A-imm
  - 1000 A>>>B arithmetic
  - 1001 A&B
  - 1010 A|B
  - 1011 A^B
  - 1100-1111 illegal: result 0, op_err=1, flags 0.
- Shifts: if B >= WIDTH (any bit above SHW set), result is 0 for sll/srl and all copies of A[WIDTH-1] for sra. Otherwise shift by B[SHW-1:0].
- flag_carry:
  - add forms: carry-out.
  - sub forms: 1 when unsigned borrow (A < operand).
  - mul: 1 when the upper WIDTH bits of the full product are nonzero.
  - all other ops: 0.
- flag_ovf: signed overflow for add/sub/addi/subi; 0 otherwise. flag_zero is computed from the final result for every op, including illegal ones.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch operands and opcode. Go to MUL if op=0001, else compute and go to DONE.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, counter from WIDTH-1 down to 0. At count 0, register the result and flags and go to DONE.
  - DONE: out_valid=1, and result/flags are held stable. On out_ready, go to IDLE.
- Latency, with the accept edge as cycle 0:
  - non-mul ops: out_valid high from cycle 1.
  - mul: out_valid high from cycle WIDTH+1.
- Throughput: at most one op per 2 cycles for single-cycle ops, since in_ready=0 in DONE.
- Inputs are ignored outside IDLE. Operand changes during MUL/DONE do not affect the result.
- out_valid stays high, with result unchanged, for as long as out_ready is low.
- Reset takes effect on any cycle:
  - state goes to IDLE, in_ready=1.
  - out_valid, result, all flags and op_err go to 0.
  - the multiplier accumulator and counter clear.
  - an in-flight op is discarded with no output.
- rst has priority over simultaneous in_valid or out_ready.
- All arithmetic is modulo 2^WIDTH; carry/borrow are computed on a WIDTH+1-bit intermediate.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ZERO, OP_MUL, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_ADDI, OP_SUBI, OP_SRA, OP_AND, OP_OR, OP_XOR).
  - the 2-bit FSM state enum (IDLE, MUL, DONE).
- One sub-module, alu_shift_add_mul: a WIDTH-parametrised iterative multiplier with start/done, busy counter, and a 2*WIDTH-bit accumulator. The top FSM drives start and samples done.
- All single-cycle ops stay combinational inside alu_seq, with registered capture.

Test Plan:
- Reset sequencing: rst for 2 cycles -> in_ready=1, out_valid=0, result=0, all flags 0. Then assert rst during MUL cycle 5 -> IDLE next cycle, out_valid stays 0.
- Add overflow/carry: WIDTH=32, op 0010, A=0xFFFFFFFF, B=1 -> out_valid at cycle 1, result=0, zero=1, carry=1, ovf=0. Then A=0x7FFFFFFF, B=1 -> result=0x80000000, ovf=1, carry=0.
- Subtract borrow and immediate: op 0111, A=3, imm=5 -> result=0xFFFFFFFE, carry=1, ovf=0. Then op 0011, A=0x80000000, B=1 -> result=0x7FFFFFFF, ovf=1.
- Shift boundaries: op 1000, A=0x80000000, B=31 -> 0xFFFFFFFF. Then B=32 -> 0xFFFFFFFF. Then op 0100, A=1, B=40 -> 0, zero=1.
- Multiply latency/backpressure: op 0001, A=0x10000, B=0x10001 -> out_valid first at cycle 33, result=0x00010000, carry=1. Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout. Pulse out_ready -> IDLE next cycle.
- Illegal opcode plus WIDTH=8 build: op 1110 -> result 0, op_err=1, zero=1. Then op 0001, A=15, B=17 -> result=0xFF after 9 cycles, carry=0.
